// File: rtl/psoc_audio_pkg.sv
// Shared definitions for the PSoC audio blocks.
// - AUDIO_SAMPLE_BITS / AUDIO_FRAME_BITS: per-channel width and the {L,R} word
//   layout used by the audio FIFOs (left channel in the upper half).
// - rx_state_e: I2S receiver framing state.
package psoc_audio_pkg;

    localparam int AUDIO_SAMPLE_BITS = 24;
    localparam int AUDIO_FRAME_BITS  = 2 * AUDIO_SAMPLE_BITS;

    typedef enum logic [1:0] {
        RX_SYNC  = 2'd0,
        RX_LEFT  = 2'd1,
        RX_RIGHT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchroniser for the three asynchronous I2S pins.
// All pins go through the same number of stages so that lrclk and sdata line up
// with the sclk edge that is detected from them.
// Ports:
//   clk, rst            system clock, async active-high reset
//   sclk_in/lrclk_in/sdata_in   raw pins
//   sclk_rise           1-cycle strobe on a synced sclk 0->1
//   lr, sdata           synced lrclk / sdata, valid alongside sclk_rise
module i2s_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_in,
    input  logic lrclk_in,
    input  logic sdata_in,
    output logic sclk_rise,
    output logic lr,
    output logic sdata
);

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
    logic [SYNC_STAGES-1:0] lr_q, lr_d;
    logic [SYNC_STAGES-1:0] sd_q, sd_d;
    logic                   sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk_in};
        lr_d        = {lr_q[SYNC_STAGES-2:0], lrclk_in};
        sd_d        = {sd_q[SYNC_STAGES-2:0], sdata_in};
        sclk_prev_d = sclk_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= '0;
            lr_q        <= '0;
            sd_q        <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            lr_q        <= lr_d;
            sd_q        <= sd_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign lr        = lr_q[SYNC_STAGES-1];
    assign sdata     = sd_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: deserialises standard I2S frames (MSB first, one-bit
// delay after the lrclk edge, lrclk low = left) from an external master and
// presents {left, right} words on a valid/ready port.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   enable                   receiver enable; low drops any partial frame
//   i2s_sclk/lrclk/sdata     asynchronous I2S pins
//   sample_data/valid/ready  output word, held until consumed
//   overrun                  sticky: a finished frame found the output full
//   frame_error              sticky: a slot shorter than SAMPLE_BITS was seen
//   clear_flags              pulse clearing both sticky flags
module i2s_slave_rx
    import psoc_audio_pkg::*;
#(
    parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     i2s_sclk,
    input  logic                     i2s_lrclk,
    input  logic                     i2s_sdata,
    output logic [2*SAMPLE_BITS-1:0] sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     overrun,
    output logic                     frame_error,
    input  logic                     clear_flags
);

    localparam logic [6:0] SLOT_MIN = 7'(SAMPLE_BITS);

    logic sclk_rise, lr_s, sdata_s;

    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (i2s_sclk),
        .lrclk_in  (i2s_lrclk),
        .sdata_in  (i2s_sdata),
        .sclk_rise (sclk_rise),
        .lr        (lr_s),
        .sdata     (sdata_s)
    );

    rx_state_e                 state_q, state_d;
    logic [5:0]                bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_BITS-1:0]    shift_q, shift_d;
    logic [SAMPLE_BITS-1:0]    left_hold_q, left_hold_d;
    logic                      lr_prev_q, lr_prev_d;
    logic [2*SAMPLE_BITS-1:0]  data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      overrun_q, overrun_d;
    logic                      ferr_q, ferr_d;
    logic                      frame_done, slot_err, trans;
    logic [6:0]                rcvd;

    // Framing: the bit sampled on the lrclk transition edge still belongs to
    // the slot being closed, so it is shifted in before the slot is judged.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        lr_prev_d   = lr_prev_q;
        frame_done  = 1'b0;
        slot_err    = 1'b0;
        trans       = (lr_s != lr_prev_q);
        rcvd        = {1'b0, bit_cnt_q} + 7'd1;

        if (sclk_rise) lr_prev_d = lr_s;

        if (!enable) begin
            state_d   = RX_SYNC;
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            case (state_q)
                RX_LEFT, RX_RIGHT: begin
                    // Bits beyond SAMPLE_BITS are slot padding and are dropped.
                    if ({1'b0, bit_cnt_q} < SLOT_MIN)
                        shift_d = {shift_q[SAMPLE_BITS-2:0], sdata_s};
                    bit_cnt_d = (bit_cnt_q == 6'd63) ? bit_cnt_q : bit_cnt_q + 6'd1;
                    if (trans) begin
                        bit_cnt_d = '0;
                        if (rcvd < SLOT_MIN) begin
                            slot_err = 1'b1;
                            state_d  = RX_SYNC;
                        end else if (state_q == RX_LEFT) begin
                            left_hold_d = shift_d;
                            state_d     = RX_RIGHT;
                        end else begin
                            frame_done = 1'b1;
                            state_d    = RX_LEFT;
                        end
                    end
                end
                default: begin
                    // Lock onto the start of a left slot; the edge bit is the
                    // previous right LSB and is not wanted.
                    if (lr_prev_q && !lr_s) begin
                        state_d   = RX_LEFT;
                        bit_cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Output register and sticky flags; a set event beats clear_flags.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q & ~clear_flags;
        ferr_d    = ferr_q & ~clear_flags;

        if (valid_q && sample_ready) valid_d = 1'b0;

        if (frame_done) begin
            if (!valid_q || sample_ready) begin
                data_d  = {left_hold_q, shift_d};
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (slot_err) ferr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_SYNC;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            lr_prev_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            lr_prev_q   <= lr_prev_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_error  = ferr_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
module tb_i2s_slave_rx;

    localparam int SYNC_STAGES = 2;

    logic        clk, rst, enable;
    logic        i2s_sclk, i2s_lrclk, i2s_sdata;
    logic [47:0] sample_data;
    logic        sample_valid, sample_ready;
    logic        overrun, frame_error, clear_flags;

    i2s_slave_rx #(.SAMPLE_BITS(24), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_error  (frame_error),
        .clear_flags  (clear_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          slot;
        logic        pad;
        logic [47:0] exp;
    } vec_t;

    vec_t        tbl[4];
    logic [47:0] sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One sclk period = 8 clk. Pins change with sclk falling; the DUT samples
    // on the rise. With clr set, clear_flags is pulsed in the exact clk cycle
    // the DUT acts on this rise.
    task automatic send_bit(input logic lr, input logic d, input logic clr);
        i2s_sclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = d;
        repeat (4) @(negedge clk);
        i2s_sclk = 1'b1;
        if (clr) begin
            repeat (SYNC_STAGES) @(negedge clk);
            clear_flags = 1'b1;
            @(negedge clk);
            clear_flags = 1'b0;
            repeat (3 - SYNC_STAGES) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    // Bits first..last of one slot; the final slot bit goes out with the next
    // slot's lrclk level (I2S one-bit delay).
    task automatic send_bits(input logic [23:0] v, input int slot, input logic pad,
                             input logic lr_slot, input int first, input int last,
                             input logic clr);
        for (int i = first; i <= last; i++) begin
            logic d, lr;
            d  = (i < 24) ? v[23-i] : pad;
            lr = (i == slot - 1) ? ~lr_slot : lr_slot;
            send_bit(lr, d, clr && (i == slot - 1));
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int slot_l,
                              input int slot_r, input logic pad, input logic clr);
        send_bits(l, slot_l, pad, 1'b0, 0, slot_l - 1, 1'b0);
        send_bits(r, slot_r, pad, 1'b1, 0, slot_r - 1, clr);
    endtask

    // Gives the receiver a 1->0 lrclk edge to lock onto.
    task automatic preamble();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard: every accepted word must be the next expected one.
    always @(negedge clk) begin
        #1;
        if (!rst && sample_valid && sample_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: got word %h, expected no valid", sample_data);
            end else begin
                chk("frame_data", sample_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        tbl[0] = '{24'hABCDEF, 24'h123456, 24, 1'b0, 48'hABCDEF123456};
        tbl[1] = '{24'h800001, 24'h7FFFFF, 32, 1'b1, 48'h8000017FFFFF};
        tbl[2] = '{24'h5A5A5A, 24'hC3C3C3, 64, 1'b1, 48'h5A5A5AC3C3C3};
        tbl[3] = '{24'h000000, 24'hFFFFFF, 25, 1'b1, 48'h000000FFFFFF};

        rst = 1'b1; enable = 1'b1; sample_ready = 1'b1; clear_flags = 1'b0;
        i2s_sclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 48'(sample_valid), 48'd0);
        chk("rst_data", sample_data, 48'd0);
        chk("rst_overrun", 48'(overrun), 48'd0);
        chk("rst_ferr", 48'(frame_error), 48'd0);
        rst = 1'b0;

        // Table-driven frames, various slot lengths, ready held high
        preamble();
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(tbl[i].exp);
            send_frame(tbl[i].l, tbl[i].r, tbl[i].slot, tbl[i].slot, tbl[i].pad, 1'b0);
        end
        repeat (8) @(negedge clk);
        chk("drain_table", 48'(sb_q.size()), 48'd0);

        // Backpressure: A held, B dropped
        sample_ready = 1'b0;
        sb_q.push_back(48'h111111222222);
        send_frame(24'h111111, 24'h222222, 24, 24, 1'b0, 1'b0);
        send_frame(24'h333333, 24'h444444, 24, 24, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("ovr_valid", 48'(sample_valid), 48'd1);
        chk("ovr_data", sample_data, 48'h111111222222);
        chk("ovr_flag", 48'(overrun), 48'd1);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        chk("ovr_consumed", 48'(sample_valid), 48'd0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("ovr_cleared", 48'(overrun), 48'd0);
        chk("drain_ovr", 48'(sb_q.size()), 48'd0);

        // Short right slot
        sample_ready = 1'b1;
        send_frame(24'h0F0F0F, 24'hF0F0F0, 24, 16, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("ferr_set", 48'(frame_error), 48'd1);
        chk("ferr_no_valid", 48'(sample_valid), 48'd0);
        preamble();
        sb_q.push_back(48'h000001FFFFFE);
        send_frame(24'h000001, 24'hFFFFFE, 24, 24, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("drain_ferr", 48'(sb_q.size()), 48'd0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("ferr_cleared", 48'(frame_error), 48'd0);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 24, 16, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("ferr_set_beats_clear", 48'(frame_error), 48'd1);

        // enable dropped mid right slot
        preamble();
        send_bits(24'h123123, 24, 1'b0, 1'b0, 0, 23, 1'b0);
        send_bits(24'h456456, 24, 1'b0, 1'b1, 0, 9, 1'b0);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(24'h456456, 24, 1'b0, 1'b1, 10, 11, 1'b0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        send_bits(24'h456456, 24, 1'b0, 1'b1, 12, 23, 1'b0);
        repeat (4) @(negedge clk);
        chk("en_no_partial", 48'(sb_q.size()), 48'd0);
        sb_q.push_back(48'h789789ABCABC);
        send_frame(24'h789789, 24'hABCABC, 24, 24, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("drain_en", 48'(sb_q.size()), 48'd0);

        // Reset mid-left-slot with a held word and both flags set
        sample_ready = 1'b0;
        send_frame(24'hC0FFEE, 24'h00BEEF, 24, 24, 1'b0, 1'b0);
        send_frame(24'h999999, 24'h888888, 24, 24, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_data", sample_data, 48'hC0FFEE00BEEF);
        chk("pre_rst_ovr", 48'(overrun), 48'd1);
        send_bits(24'h654321, 24, 1'b0, 1'b0, 0, 7, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstm_valid", 48'(sample_valid), 48'd0);
        chk("rstm_data", sample_data, 48'd0);
        chk("rstm_overrun", 48'(overrun), 48'd0);
        chk("rstm_ferr", 48'(frame_error), 48'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sample_ready = 1'b1;
        send_bits(24'h654321, 24, 1'b0, 1'b0, 8, 23, 1'b0);
        send_bits(24'hFEDCBA, 24, 1'b0, 1'b1, 0, 23, 1'b0);
        repeat (4) @(negedge clk);
        chk("rstm_no_valid", 48'(sample_valid), 48'd0);
        sb_q.push_back(48'h13579B2468AC);
        send_frame(24'h13579B, 24'h2468AC, 24, 24, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("drain_rst", 48'(sb_q.size()), 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
